seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the 32-bit ripple-carry ALU.
- Keeps the same ALU_control encodings for AND/OR/ADD/SUB/SLT and adds NOR.
- Adds two iterative operations: unsigned shift-add multiply (MULU) and unsigned restoring divide (DIVU).
- Sits in the execute stage; the datapath starts an operation with start and waits for done, using busy to stall.

Parameters:
- WIDTH, 32, operand and result width in bits (legal values are 4 and above).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted on an edge where start=1 and busy=0.
- ALU_control  in  4  operation select, sampled with start.
- src1  in  WIDTH  operand A, sampled with start.
- src2  in  WIDTH  operand B, sampled with start.
- busy  out  1  a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  main result (product low half, or quotient).
- result_hi  out  WIDTH  product high half (MULU), remainder (DIVU), 0 for all other ops.
- zero  out  1  set when result == 0.
- cout  out  1  carry out of the MSB (ADD/SUB only).
- overflow  out  1  signed overflow (ADD/SUB only).
- div_by_zero  out  1  DIVU issued with src2 == 0.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: busy, done, result, result_hi, zero, cout, overflow and div_by_zero all go to 0.
  - State: FSM returns to IDLE, iteration counter cleared.
  - A reset mid-operation aborts it with no done pulse.
- Encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULU, 1001 DIVU.
  - Any other code: result=0, all flags 0, done after 1 cycle.
- FSM states: IDLE, MUL, DIV.
- Single-cycle ops (accepted at edge k):
  - result and flags are registered at edge k; done=1 for the cycle after edge k.
  - busy stays 0; FSM stays in IDLE.
- ADD/SUB/SLT arithmetic:
  - Sum = src1 + (src2 ^ {WIDTH{sub}}) + sub, computed in WIDTH+1 bits; cout = bit WIDTH.
  - overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted src2.
  - SLT: result = {0…, sum_msb ^ overflow}. This is a correct signed compare even when the subtraction overflows. cout and overflow are forced to 0 for SLT.
- MULU (accepted at edge k):
  - Enter MUL; busy=1 from edge k.
  - One shift-add step per edge, WIDTH steps total.
  - At edge k+WIDTH: {result_hi, result} = full 2·WIDTH-bit product, busy=0, done=1 for one cycle, FSM to IDLE.
- DIVU, src2 != 0:
  - Enter DIV; restoring division, one quotient bit per edge, WIDTH steps.
  - At edge k+WIDTH: result = quotient, result_hi = remainder, busy=0, done pulse.
- DIVU, src2 == 0:
  - No iteration; at edge k: result = all ones, result_hi = src1, div_by_zero=1, done next cycle.
- Flags on MULU/DIVU:
  - cout=0 and overflow=0.
  - zero reflects result only.
- Output hold:
  - Outputs hold their last values until the next completion.
  - Flags and result update only at completion, never during iteration.
  - div_by_zero is cleared on any other completion.
- Handshake rules:
  - start while busy=1 is ignored, and operands are not re-latched.
  - start in the done cycle is accepted, since busy=0 then; back-to-back throughput is 1 op/cycle for single-cycle ops.
  - Operand inputs may change freely after acceptance.

Test Plan:
- Reset mid-op: rst pulsed during the 5th MULU step -> busy=0, FSM IDLE, no done pulse, all outputs 0; the next ADD completes normally.
- ADD overflow: WIDTH=32, ADD 0x7FFFFFFF + 1 -> result 0x80000000, overflow=1, cout=0, zero=0, done one cycle after the accepting edge.
- SUB carry/zero: SUB 5 - 5 -> result 0, zero=1, cout=1. SLT 0x80000000 vs 1 -> result 1. SLT 1 vs 0x80000000 -> result 0.
- MULU timing: MULU 0xFFFFFFFF × 0xFFFFFFFF -> at edge k+32, result_hi 0xFFFFFFFE and result 0x00000001. busy high for exactly 32 cycles. A start asserted at cycle k+3 with ADD is ignored.
- DIVU: DIVU 100 / 7 -> result 14, result_hi 2, done at k+32. DIVU 9 / 0 -> result 0xFFFFFFFF, result_hi 9, div_by_zero=1, done after 1 cycle.
- WIDTH=8 rebuild: MULU 200 × 3 -> result_hi 0x02, result 0x58 at k+8. Encoding 1111 -> result 0, flags 0, done after 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle logic/arithmetic ops and
// iterative unsigned multiply (shift-add) and divide (restoring).
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         request, accepted when start=1 and busy=0
//   ALU_control   operation select, sampled with start
//   src1, src2    operands, sampled with start
//   busy          multi-cycle operation in progress
//   done          one-cycle pulse, result/flags valid from this cycle
//   result        main result (product low half / quotient)
//   result_hi     product high half / remainder, 0 otherwise
//   zero, cout, overflow, div_by_zero   status flags
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;   // {partial high, remaining multiplier}
  logic [WIDTH-1:0]   opa_q, opa_d;     // multiplicand or divisor
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  // Single-cycle adder: SUB and SLT both use src1 + ~src2 + 1.
  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;

  always_comb begin
    sub_op  = (ALU_control == OP_SUB) || (ALU_control == OP_SLT);
    b_eff   = src2 ^ {WIDTH{sub_op}};
    sum     = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    add_ovf = (src1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
  end

  // One shift-add step: conditionally add multiplicand to the high half,
  // keep the carry, then shift the whole product right by one.
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
    mul_next = {mul_add, prod_q[WIDTH-1:1]};
  end

  // One restoring-divide step. The partial remainder is always below the
  // divisor, so the shifted value minus divisor fits WIDTH bits when
  // non-negative and bit WIDTH acts as the borrow.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opa_q};
    div_bit   = ~div_trial[WIDTH];
    rem_next  = div_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], div_bit};
  end

  // Completion bundle: outputs only move when fin is set.
  logic             fin;
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH-1:0] fin_hi;
  logic             fin_c;
  logic             fin_o;
  logic             fin_dbz;
  logic             fin_zok;   // cleared for illegal codes, whose flags are all 0

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    opa_d       = opa_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    fin         = 1'b0;
    fin_res     = '0;
    fin_hi      = '0;
    fin_c       = 1'b0;
    fin_o       = 1'b0;
    fin_dbz     = 1'b0;
    fin_zok     = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fin = 1'b1;
          case (ALU_control)
            OP_AND: fin_res = src1 & src2;
            OP_OR:  fin_res = src1 | src2;
            OP_NOR: fin_res = ~(src1 | src2);
            OP_ADD, OP_SUB: begin
              fin_res = sum[WIDTH-1:0];
              fin_c   = sum[WIDTH];
              fin_o   = add_ovf;
            end
            // Sign of the difference corrected by overflow gives a true signed compare.
            OP_SLT: fin_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            OP_MULU: begin
              fin     = 1'b0;
              state_d = S_MUL;
              cnt_d   = '0;
              prod_d  = {{WIDTH{1'b0}}, src2};
              opa_d   = src1;
            end
            OP_DIVU: begin
              if (src2 == '0) begin
                fin_res = '1;
                fin_hi  = src1;
                fin_dbz = 1'b1;
              end else begin
                fin     = 1'b0;
                state_d = S_DIV;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = src1;
                opa_d   = src2;
              end
            end
            default: fin_zok = 1'b0;
          endcase
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          fin     = 1'b1;
          fin_res = mul_next[WIDTH-1:0];
          fin_hi  = mul_next[2*WIDTH-1:WIDTH];
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_DIV: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          fin     = 1'b1;
          fin_res = quo_next;
          fin_hi  = rem_next;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      result_d    = fin_res;
      result_hi_d = fin_hi;
      zero_d      = fin_zok && (fin_res == '0);
      cout_d      = fin_c;
      ovf_d       = fin_o;
      dbz_d       = fin_dbz;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      opa_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      opa_q       <= opa_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      done_q      <= done_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: a 32-bit and an 8-bit instance, table-driven
// vectors through a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_seq_alu;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        c;
    logic        o;
    logic        d;
    int          lat;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        c;
    logic        o;
    logic        d;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start8;
  logic [3:0]  ctrl, ctrl8;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;
  logic        busy, done, zero, cout, overflow, div_by_zero;
  logic [31:0] result, result_hi;
  logic        busy8, done8, zero8, cout8, overflow8, div_by_zero8;
  logic [7:0]  result8, result_hi8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q[$];
  exp_t q8[$];
  exp_t em, em8;
  vec_t tbl[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_control(ctrl),
    .src1(a), .src2(b), .busy(busy), .done(done), .result(result),
    .result_hi(result_hi), .zero(zero), .cout(cout), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ALU_control(ctrl8),
    .src1(a8), .src2(b8), .busy(busy8), .done(done8), .result(result8),
    .result_hi(result_hi8), .zero(zero8), .cout(cout8), .overflow(overflow8),
    .div_by_zero(div_by_zero8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void add_vec(input logic [3:0] c_, input logic [31:0] a_, input logic [31:0] b_,
                                  input logic [31:0] r_, input logic [31:0] h_,
                                  input logic z_, input logic co_, input logic o_, input logic d_,
                                  input int l_);
    vec_t v;
    v.ctrl = c_; v.a = a_; v.b = b_; v.res = r_; v.hi = h_;
    v.z = z_; v.c = co_; v.o = o_; v.d = d_; v.lat = l_;
    tbl.push_back(v);
  endfunction

  task automatic issue(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    start = 1'b1; ctrl = v.ctrl; a = v.a; b = v.b;
    e.tag = tag; e.res = v.res; e.hi = v.hi; e.z = v.z; e.c = v.c; e.o = v.o; e.d = v.d;
    e.cyc = cyc + 1 + v.lat;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic issue8(input string tag, input logic [3:0] c_, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] r_, input logic [7:0] h_,
                        input logic z_, input logic co_, input logic o_, input int l_);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; ctrl8 = c_; a8 = x; b8 = y;
    e.tag = tag; e.res = {24'h0, r_}; e.hi = {24'h0, h_}; e.z = z_; e.c = co_; e.o = o_; e.d = 1'b0;
    e.cyc = cyc + 1 + l_;
    q8.push_back(e);
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d results still outstanding, required 0", q.size(), q8.size());
      q.delete();
      q8.delete();
    end
  endtask

  task automatic check_idle32(input string tag);
    checks++;
    if ({busy, done, result, result_hi, zero, cout, overflow, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b res=%h hi=%h z=%b c=%b v=%b dz=%b, required all 0",
               tag, busy, done, result, result_hi, zero, cout, overflow, div_by_zero);
    end else
      $display("txn %s: outputs all 0", tag);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done32: got done with res=%h, required no done", result);
      end else begin
        em = q.pop_front();
        if ({result, result_hi, zero, cout, overflow, div_by_zero} !== {em.res, em.hi, em.z, em.c, em.o, em.d}) begin
          errors++;
          $display("FAIL %s: got res=%h hi=%h z=%b c=%b v=%b dz=%b, required res=%h hi=%h z=%b c=%b v=%b dz=%b",
                   em.tag, result, result_hi, zero, cout, overflow, div_by_zero,
                   em.res, em.hi, em.z, em.c, em.o, em.d);
        end
        checks++;
        if (cyc != em.cyc) begin
          errors++;
          $display("FAIL %s_latency: done at edge %0d, required %0d", em.tag, cyc, em.cyc);
        end
        $display("txn %s: res=%h hi=%h z=%b c=%b v=%b dz=%b edge=%0d",
                 em.tag, result, result_hi, zero, cout, overflow, div_by_zero, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done8: got done with res=%h, required no done", result8);
      end else begin
        em8 = q8.pop_front();
        if ({result8, result_hi8, zero8, cout8, overflow8, div_by_zero8} !==
            {em8.res[7:0], em8.hi[7:0], em8.z, em8.c, em8.o, em8.d}) begin
          errors++;
          $display("FAIL %s: got res=%h hi=%h z=%b c=%b v=%b dz=%b, required res=%h hi=%h z=%b c=%b v=%b dz=%b",
                   em8.tag, result8, result_hi8, zero8, cout8, overflow8, div_by_zero8,
                   em8.res[7:0], em8.hi[7:0], em8.z, em8.c, em8.o, em8.d);
        end
        checks++;
        if (cyc != em8.cyc) begin
          errors++;
          $display("FAIL %s_latency: done at edge %0d, required %0d", em8.tag, cyc, em8.cyc);
        end
        $display("txn %s: res=%h hi=%h z=%b c=%b v=%b edge=%0d",
                 em8.tag, result8, result_hi8, zero8, cout8, overflow8, cyc);
      end
    end
  end

  initial begin
    vec_t v;
    int   nbusy;

    //       ctrl     src1          src2          result        result_hi     z  c  v  dz lat
    add_vec(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        0, 0, 1, 0, 0);
    add_vec(4'b0110, 32'd5,        32'd5,        32'h0,        32'h0,        1, 1, 0, 0, 0);
    add_vec(4'b0111, 32'h80000000, 32'h00000001, 32'h1,        32'h0,        0, 0, 0, 0, 0);
    add_vec(4'b0111, 32'h00000001, 32'h80000000, 32'h0,        32'h0,        1, 0, 0, 0, 0);
    add_vec(4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 0, 0, 0, 0);
    add_vec(4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,        0, 0, 0, 0, 0);
    add_vec(4'b0001, 32'hF0000000, 32'h00000001, 32'hF0000001, 32'h0,        0, 0, 0, 0, 0);
    add_vec(4'b1100, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        0, 0, 0, 0, 0);
    add_vec(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        1, 1, 0, 0, 0);
    add_vec(4'b0110, 32'h0,        32'h00000001, 32'hFFFFFFFF, 32'h0,        0, 0, 0, 0, 0);
    add_vec(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        0, 1, 1, 0, 0);
    add_vec(4'b1111, 32'h1,        32'h2,        32'h0,        32'h0,        0, 0, 0, 0, 0);
    add_vec(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 0, 32);
    add_vec(4'b1000, 32'h00010000, 32'h00010000, 32'h0,        32'h1,        1, 0, 0, 0, 32);
    add_vec(4'b1000, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 32'h0,        0, 0, 0, 0, 32);
    add_vec(4'b1001, 32'd100,      32'd7,        32'd14,       32'd2,        0, 0, 0, 0, 32);
    add_vec(4'b1001, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        0, 0, 0, 1, 0);
    add_vec(4'b1001, 32'd5,        32'd10,       32'h0,        32'd5,        1, 0, 0, 0, 32);
    add_vec(4'b1001, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h0,        0, 0, 0, 0, 32);
    add_vec(4'b0010, 32'd1,        32'd1,        32'd2,        32'h0,        0, 0, 0, 0, 0);

    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    ctrl = 4'h0; ctrl8 = 4'h0; a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle32("reset_state");

    // Table: single-cycle ops go back-to-back, multi-cycle ops drain first.
    for (int i = 0; i < tbl.size(); i++) begin
      issue($sformatf("vec%0d_op%b", i, tbl[i].ctrl), tbl[i]);
      if (tbl[i].lat != 0) drain();
    end
    drain();

    // MULU with an ADD request during busy that must be ignored.
    v.ctrl = 4'b1000; v.a = 32'hFFFFFFFF; v.b = 32'hFFFFFFFF; v.res = 32'h00000001; v.hi = 32'hFFFFFFFE;
    v.z = 1'b0; v.c = 1'b0; v.o = 1'b0; v.d = 1'b0; v.lat = 32;
    issue("mulu_busy_ignore", v);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      nbusy++;
      start = (i == 2);
      ctrl  = 4'b0010;
      a     = 32'd3;
      b     = 32'd4;
    end
    start = 1'b0;
    checks++;
    if (nbusy != 32) begin
      errors++;
      $display("FAIL mulu_busy_cycles: got %0d, required 32", nbusy);
    end else
      $display("txn mulu_busy_cycles: busy for %0d cycles", nbusy);
    drain();

    // Reset during the 5th MULU step aborts the operation with no done.
    v.ctrl = 4'b1000; v.a = 32'd3; v.b = 32'd3; v.res = 32'd9; v.hi = 32'h0; v.z = 1'b0; v.lat = 32;
    issue("mulu_aborted", v);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    q.delete();
    #1;
    check_idle32("reset_mid_mulu");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    v.ctrl = 4'b0010; v.a = 32'd3; v.b = 32'd4; v.res = 32'd7; v.hi = 32'h0; v.lat = 0;
    issue("add_after_reset", v);
    drain();

    // Narrow instance.
    issue8("w8_mulu", 4'b1000, 8'd200, 8'd3, 8'h58, 8'h02, 1'b0, 1'b0, 1'b0, 8);
    drain();
    issue8("w8_illegal", 4'b1111, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    issue8("w8_add_ovf", 4'b0010, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 0);
    issue8("w8_divu", 4'b1001, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 1'b0, 8);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
